// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Brief    : Command, register-bank and result bundle for alu_sequencer.
// Revision : 1.0
// ============================================================================
interface alu_sequencer_if #(
  parameter int REGISTERS_COUNT = 2,
  parameter int ADDR_W          = $clog2(REGISTERS_COUNT)
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [2:0]                   cmd_op;
  logic [ADDR_W-1:0]            cmd_src_a;
  logic [ADDR_W-1:0]            cmd_src_b;
  logic [ADDR_W-1:0]            cmd_dst;
  logic [8*REGISTERS_COUNT-1:0] reg_bus;
  logic [7:0]                   wr_data;
  logic                         wr_store;
  logic [ADDR_W-1:0]            wr_address;
  logic                         done;
  logic [7:0]                   res_data;
  logic                         res_carry;
  logic                         res_zero;
  logic                         res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, reg_bus,
    input  cmd_ready, wr_data, wr_store, wr_address, done,
           res_data, res_carry, res_zero, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, reg_bus,
    output cmd_ready, wr_data, wr_store, wr_address, done,
           res_data, res_carry, res_zero, res_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Runs one two-operand ALU command per handshake against a register
//            bank, writes the result back and reports flags.
// Revision : 1.0
// ============================================================================
module alu_sequencer #(
  parameter int REGISTERS_COUNT = 2,
  parameter int ADDR_W          = $clog2(REGISTERS_COUNT)
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  localparam logic [ADDR_W:0] c_reg_count = (ADDR_W+1)'(REGISTERS_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_src_a;
  logic [ADDR_W-1:0] r_src_b;
  logic [ADDR_W-1:0] r_dst;
  logic [7:0]        r_wr_data;
  logic              r_wr_store;
  logic [ADDR_W-1:0] r_wr_address;
  logic              r_done;
  logic [7:0]        r_res_data;
  logic              r_res_carry;
  logic              r_res_zero;
  logic              r_res_err;

  logic [7:0]        w_op_a;
  logic [7:0]        w_op_b;
  logic [8:0]        w_temp;
  logic              w_err;

  // Explicit mux so an out-of-range index never forms an out-of-bounds select.
  always_comb begin
    w_op_a = 8'h00;
    w_op_b = 8'h00;
    for (int i = 0; i < REGISTERS_COUNT; i++) begin
      if (r_src_a == ADDR_W'(i)) w_op_a = bus.reg_bus[8*i +: 8];
      if (r_src_b == ADDR_W'(i)) w_op_b = bus.reg_bus[8*i +: 8];
    end
  end

  // Bit 8 carries ADD carry-out, SUB borrow, or the bit shifted out.
  always_comb begin
    w_temp = 9'h000;
    case (r_op)
      3'd0: w_temp = {1'b0, w_op_a} + {1'b0, w_op_b};
      3'd1: w_temp = {1'b0, w_op_a} - {1'b0, w_op_b};
      3'd2: w_temp = {1'b0, w_op_a & w_op_b};
      3'd3: w_temp = {1'b0, w_op_a | w_op_b};
      3'd4: w_temp = {1'b0, w_op_a ^ w_op_b};
      3'd5: w_temp = {1'b0, ~w_op_a};
      3'd6: w_temp = {w_op_a[7], w_op_a[6:0], 1'b0};
      default: w_temp = {w_op_a[0], 1'b0, w_op_a[7:1]};
    endcase
  end

  assign w_err = ({1'b0, r_src_a} >= c_reg_count)
              || ((r_op <= 3'd4) && ({1'b0, r_src_b} >= c_reg_count))
              || ({1'b0, r_dst} >= c_reg_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_op         <= 3'd0;
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_dst        <= '0;
      r_wr_data    <= 8'h00;
      r_wr_store   <= 1'b0;
      r_wr_address <= '0;
      r_done       <= 1'b0;
      r_res_data   <= 8'h00;
      r_res_carry  <= 1'b0;
      r_res_zero   <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_op        <= bus.cmd_op;
            r_src_a     <= bus.cmd_src_a;
            r_src_b     <= bus.cmd_src_b;
            r_dst       <= bus.cmd_dst;
            r_cmd_ready <= 1'b0;
            r_state     <= S_EXEC;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_EXEC: begin
          r_res_data  <= w_temp[7:0];
          r_res_carry <= w_temp[8];
          r_res_zero  <= (w_temp[7:0] == 8'h00);
          r_res_err   <= w_err;
          if (w_err) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wr_store   <= 1'b1;
            r_wr_data    <= w_temp[7:0];
            r_wr_address <= r_dst;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_wr_store <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        default: begin
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.wr_data    = r_wr_data;
  assign bus.wr_store   = r_wr_store;
  assign bus.wr_address = r_wr_address;
  assign bus.done       = r_done;
  assign bus.res_data   = r_res_data;
  assign bus.res_carry  = r_res_carry;
  assign bus.res_zero   = r_res_zero;
  assign bus.res_err    = r_res_err;

endmodule
`default_nettype wire
